// File: rtl/rrelu_pkg.sv
// Shared constants and helpers for the forward and backward rrelu blocks.
// Keeping slope masking and beat counting here stops the two directions drifting apart.
`timescale 1ns/1ps
package rrelu_pkg;

    localparam int          LFSR_W            = 32;
    localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h04c11db7;
    localparam logic [31:0] DEFAULT_SEED      = 32'hffffffff;

    // Keeps bits [p1-upper-1 : p1-lower] so the slope lies in [0, 2^-upper) with 2^-lower steps.
    function automatic logic [31:0] slope_mask(input int p1, input int upper, input int lower);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (b >= p1 - lower && b <= p1 - upper - 1) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic int beats(input int dim0, input int dim1, input int lanes);
        return (dim0 * dim1) / lanes;
    endfunction

endpackage

// File: rtl/lfsr.sv
// One combinational LFSR step: state_out = step(state_in).
// Latency 0, no handshake; the caller owns the state register.
`timescale 1ns/1ps
module lfsr #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = 32'h04c11db7,
    parameter string           STYLE = "AUTO"
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    generate
        if (STYLE == "FIBONACCI") begin : g_fib
            assign state_out = {state_in[WIDTH-2:0], ^(state_in & POLY)};
        end else begin : g_galois
            // AUTO resolves to the Galois form: a single XOR level behind the shift.
            assign state_out = {state_in[WIDTH-2:0], 1'b0} ^ (state_in[WIDTH-1] ? POLY : '0);
        end
    endgenerate

endmodule

// File: rtl/fixed_rrelu_backward.sv
// Randomized leaky ReLU backward: grad_in = (x < 0) ? slope * grad_out : grad_out, per lane.
// Latency 2 cycles, 1 beat/cycle; input ready follows the output stall through the two stages.
`timescale 1ns/1ps
module fixed_rrelu_backward
    import rrelu_pkg::*;
#(
    parameter int          DATA_IN_0_PRECISION_0       = 16,
    parameter int          DATA_IN_0_PRECISION_1       = 8,
    parameter int          DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int          DATA_IN_0_TENSOR_SIZE_DIM_1 = 4,
    parameter int          DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int          DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int          DATA_OUT_0_PRECISION_0      = 16,
    parameter int          DATA_OUT_0_PRECISION_1      = 8,
    parameter int          UPPER                       = 1,
    parameter int          LOWER                       = 4,
    parameter logic [31:0] LFSR_POLY                   = DEFAULT_LFSR_POLY,
    parameter logic [31:0] SEED                        = DEFAULT_SEED,
    parameter bit          RESEED_PER_TENSOR           = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_1 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int N      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int P0     = DATA_IN_0_PRECISION_0;
    localparam int P1     = DATA_IN_0_PRECISION_1;
    localparam int OUT_P0 = DATA_OUT_0_PRECISION_0;
    localparam int PW     = 2 * P0;
    localparam int BEATS  = beats(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1, N);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [31:0]          MASK_FULL = slope_mask(P1, UPPER, LOWER);
    localparam logic [P0-1:0]        MASK      = {1'b0, MASK_FULL[P0-2:0]};
    localparam logic signed [P0-1:0] ZERO      = '0;

    // The >>> P1 realignment only yields the output format when fractional widths agree.
    if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_bad_frac
        $error("fixed_rrelu_backward: output fractional bits must equal input fractional bits");
    end

    logic [LFSR_W-1:0]   state [N];
    logic [LFSR_W-1:0]   nxt   [N];
    logic [P0-1:0]       slope [N];
    logic signed [PW-1:0] prod [N];
    logic                x_neg [N];
    logic [CNT_W-1:0]    cnt;

    logic                 s1_vld, s2_vld;
    logic signed [PW-1:0] s1_prod [N];
    logic                 s1_xneg [N];
    logic [P0-1:0]        s1_g    [N];
    logic [OUT_P0-1:0]    s2_dat  [N];

    logic s2_load, s1_adv, accept, last_beat;

    assign s2_load         = !s2_vld || data_out_0_ready;
    assign s1_adv          = !s1_vld || s2_load;
    assign data_in_0_ready = s1_adv;
    assign accept          = data_in_0_valid && s1_adv;
    assign last_beat       = (cnt == CNT_W'(BEATS - 1));

    for (genvar i = 0; i < N; i++) begin : g_lane
        lfsr #(
            .WIDTH (LFSR_W),
            .POLY  (LFSR_POLY),
            .STYLE ("AUTO")
        ) u_lfsr (
            .state_in  (state[i]),
            .state_out (nxt[i])
        );

        // Slope comes from the stepped value so the first beat after reset sees step(SEED).
        assign slope[i] = nxt[i][P0-1:0] & MASK;
        assign prod[i]  = PW'($signed(slope[i])) * PW'($signed(data_in_0[i]));
        assign x_neg[i] = $signed(data_in_1[i]) < ZERO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < N; i++) state[i] <= SEED;
        end else if (accept) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
            for (int i = 0; i < N; i++) begin
                state[i] <= (last_beat && RESEED_PER_TENSOR) ? SEED : nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s1_prod[i] <= '0;
                s1_xneg[i] <= 1'b0;
                s1_g[i]    <= '0;
            end
        end else if (s1_adv) begin
            s1_vld <= data_in_0_valid;
            for (int i = 0; i < N; i++) begin
                s1_prod[i] <= prod[i];
                s1_xneg[i] <= x_neg[i];
                s1_g[i]    <= data_in_0[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            for (int i = 0; i < N; i++) s2_dat[i] <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            for (int i = 0; i < N; i++) begin
                s2_dat[i] <= s1_xneg[i] ? OUT_P0'(s1_prod[i] >>> P1)
                                        : OUT_P0'($signed(s1_g[i]));
            end
        end
    end

    assign data_out_0_valid = s2_vld;
    assign data_out_0       = s2_dat;

endmodule
